// File: rtl/note_lane_scheduler.sv
// note_lane_scheduler
//   On each frame tick this block takes a snapshot of the red and yellow note
//   sequences. It then sweeps every lane slot and emits one 4x4 square of
//   plot requests per slot, one pixel per clock. A slot with no note is drawn
//   black, which erases any stale note left from the previous frame. A tick
//   that arrives while a sweep is running is remembered as a single pending
//   restart. The next sweep then starts directly after the one-cycle DONE
//   state, with no idle gap.
//
//   Optional feature: define NOTE_SCHED_OVERRUN_EN to add overrun_count. It is
//   an 8-bit saturating count of ticks that were dropped because a restart
//   was already pending.
//
// Ports
//   clk            system clock
//   resetn         asynchronous active-low reset
//   tick           frame-advance pulse, sampled every rising edge
//   red_seq        red note present per slot (bit i = slot i, slot 0 leftmost)
//   yellow_seq     yellow note present per slot
//   busy           high while drawing or in the DONE cycle
//   done           one-cycle pulse at the end of a sweep
//   x, y           pixel coordinate of the current plot request
//   colour         pixel colour {R,G,B}
//   plot           pixel write strobe
//   overrun_count  dropped-tick counter (NOTE_SCHED_OVERRUN_EN only)
module note_lane_scheduler #(
  parameter int         SLOTS   = 10,
  parameter int         SPACING = 8,
  parameter logic [7:0] BASE_X  = 8'd20,
  parameter logic [6:0] BASE_Y  = 7'd56
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tick,
  input  logic [SLOTS-1:0] red_seq,
  input  logic [SLOTS-1:0] yellow_seq,
  output logic             busy,
  output logic             done,
  output logic [7:0]       x,
  output logic [6:0]       y,
  output logic [2:0]       colour,
  output logic             plot
`ifdef NOTE_SCHED_OVERRUN_EN
  ,
  output logic [7:0]       overrun_count
`endif
);

  localparam int            SW        = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [SW-1:0]    slot, slot_nx;
  // Pixel counter {yoff, xoff}: the low half steps fastest, so each square
  // is drawn in row-major order.
  logic [3:0]       pix, pix_nx;
  logic [SLOTS-1:0] snap_red, snap_red_nx;
  logic [SLOTS-1:0] snap_yel, snap_yel_nx;
  logic             pending, pending_nx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      slot     <= '0;
      pix      <= '0;
      snap_red <= '0;
      snap_yel <= '0;
      pending  <= 1'b0;
    end else begin
      state    <= state_nx;
      slot     <= slot_nx;
      pix      <= pix_nx;
      snap_red <= snap_red_nx;
      snap_yel <= snap_yel_nx;
      pending  <= pending_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    slot_nx     = slot;
    pix_nx      = pix;
    snap_red_nx = snap_red;
    snap_yel_nx = snap_yel;
    pending_nx  = pending;
    case (state)
      IDLE: begin
        if (tick) begin
          snap_red_nx = red_seq;
          snap_yel_nx = yellow_seq;
          slot_nx     = '0;
          pix_nx      = '0;
          state_nx    = DRAW;
        end
      end
      DRAW: begin
        pix_nx = pix + 4'd1;
        if (pix == 4'd15) begin
          if (slot == LAST_SLOT) begin
            // Park the counters at zero so the idle outputs match reset.
            slot_nx  = '0;
            state_nx = DONE;
          end else begin
            slot_nx = slot + SW'(1);
          end
        end
        // Any number of ticks during a sweep collapse into one restart.
        if (tick) pending_nx = 1'b1;
      end
      DONE: begin
        if (pending || tick) begin
          snap_red_nx = red_seq;
          snap_yel_nx = yellow_seq;
          slot_nx     = '0;
          pix_nx      = '0;
          pending_nx  = 1'b0;
          state_nx    = DRAW;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef NOTE_SCHED_OVERRUN_EN
  logic [7:0] ovr_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A tick that arrives while a restart is already pending is lost. Count it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovr_cnt <= 8'd0;
    end else if (tick && pending && (state != IDLE)) begin
      ovr_cnt <= sat_inc8(ovr_cnt);
    end
  end

  assign overrun_count = ovr_cnt;
`endif

  // All outputs decode from registers only; no input reaches an output.
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign plot = (state == DRAW);
  assign x    = BASE_X + 8'(32'(slot) * SPACING) + 8'(pix[1:0]);
  assign y    = BASE_Y + 7'(pix[3:2]);

  // Red takes priority when a slot carries both notes.
  always_comb begin
    colour = 3'b000;
    if (snap_red[slot])      colour = 3'b100;
    else if (snap_yel[slot]) colour = 3'b110;
  end

endmodule

// File: tb/tb_note_lane_scheduler.sv
module tb_note_lane_scheduler;

  localparam int SLOTS   = 10;
  localparam int SPACING = 8;
  localparam int BX      = 20;
  localparam int BY      = 56;
  localparam int SWEEP   = 16 * SLOTS + 1;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             tick = 1'b0;
  logic [SLOTS-1:0] red_seq = '0;
  logic [SLOTS-1:0] yellow_seq = '0;
  logic             busy, done, plot;
  logic [7:0]       x;
  logic [6:0]       y;
  logic [2:0]       colour;
`ifdef NOTE_SCHED_OVERRUN_EN
  logic [7:0]       overrun_count;
`endif

  note_lane_scheduler dut (
    .clk        (clk),
    .resetn     (resetn),
    .tick       (tick),
    .red_seq    (red_seq),
    .yellow_seq (yellow_seq),
    .busy       (busy),
    .done       (done),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot)
`ifdef NOTE_SCHED_OVERRUN_EN
    ,
    .overrun_count (overrun_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int px;
    int py;
    int col;
  } exp_t;

  exp_t q[$];
  int   vec  = 0;
  int   miss = 0;

  // Reference model state: cycles left in the current sweep (0 = idle),
  // pending restart flag, and dropped-tick count.
  int   rem  = 0;
  bit   pend = 0;
  int   ovr  = 0;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A whole sweep is a fixed list of pixels followed by one done cycle.
  task automatic start_sweep(input logic [SLOTS-1:0] r, input logic [SLOTS-1:0] yl);
    exp_t e;
    for (int s = 0; s < SLOTS; s++) begin
      for (int p = 0; p < 16; p++) begin
        e.is_done = 0;
        e.px  = (BX + s * SPACING + (p % 4)) % 256;
        e.py  = (BY + (p / 4)) % 128;
        e.col = r[s] ? 4 : (yl[s] ? 6 : 0);
        q.push_back(e);
      end
    end
    e.is_done = 1; e.px = 0; e.py = 0; e.col = 0;
    q.push_back(e);
    rem = SWEEP;
  endtask

  // Model: steps on each clock edge, flushes on reset.
  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        q.delete();
        rem = 0; pend = 0; ovr = 0;
      end else if (rem == 0) begin
        if (tick) start_sweep(red_seq, yellow_seq);
      end else begin
        if (tick && pend && ovr < 255) ovr++;
        rem--;
        if (rem == 0) begin
          if (pend || tick) begin
            pend = 0;
            start_sweep(red_seq, yellow_seq);
          end
        end else if (tick) begin
          pend = 1;
        end
      end
    end
  end

  // Monitor: compares the control outputs every cycle and pops the
  // scoreboard whenever the DUT presents a pixel or a done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        chk("busy", int'(busy), int'(rem != 0));
        chk("plot", int'(plot), int'(rem > 1));
        chk("done", int'(done), int'(rem == 1));
`ifdef NOTE_SCHED_OVERRUN_EN
        chk("overrun_count", int'(overrun_count), ovr);
`endif
        if (plot || done) begin
          if (q.size() == 0) begin
            vec++; miss++;
            $display("FAIL pop: DUT output with empty scoreboard, got plot=%0d done=%0d expected nothing", plot, done);
          end else begin
            e = q.pop_front();
            chk("kind", int'(done), int'(e.is_done));
            if (!e.is_done) begin
              chk("x", int'(x), e.px);
              chk("y", int'(y), e.py);
              chk("colour", int'(colour), e.col);
            end
          end
        end
      end
    end
  end

  task automatic drive(input bit t);
    @(posedge clk);
    #2;
    tick = t;
  endtask

  task automatic idle_n(input int n);
    repeat (n) drive(1'b0);
  endtask

  task automatic pulse();
    drive(1'b1);
    drive(1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      drive(1'b0);
      n++;
    end while (busy && n < 2 * SWEEP + 20);
    if (busy) begin
      vec++; miss++;
      $display("FAIL wait_idle: busy got 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_x", int'(x), BX);
    chk("rst_y", int'(y), BY);
`ifdef NOTE_SCHED_OVERRUN_EN
    chk("rst_overrun", int'(overrun_count), 0);
`endif
    @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b1;
    idle_n(3);
    reset_pulse();
    idle_n(2);

    // Single sweep.
    red_seq = 10'b0110101010; yellow_seq = '0;
    pulse();
    wait_idle();
    idle_n(2);

    // Colour priority and snapshot isolation.
    red_seq = 10'b0000001000; yellow_seq = 10'b0000011000;
    pulse();
    idle_n(20);
    red_seq = 10'b1111110111; yellow_seq = 10'b1010101010;
    wait_idle();

    // Pending restart. The restart must use inputs present at the DONE exit edge.
    red_seq = 10'b0000000001; yellow_seq = 10'b1000000000;
    pulse();
    idle_n(50);
    pulse();
    idle_n(60);
    red_seq = 10'b0101010101; yellow_seq = 10'b1111111111;
    wait_idle();

    // Three ticks during one sweep give one restart (and two dropped ticks).
    red_seq = 10'b1100110011; yellow_seq = 10'b0011001100;
    pulse();
    idle_n(10); pulse();
    idle_n(10); pulse();
    idle_n(10); pulse();
    wait_idle();

    // Mid-sweep reset, then a fresh sweep from slot 0.
    pulse();
    idle_n(70);
    reset_pulse();
    red_seq = 10'b0000000011; yellow_seq = 10'b0000000100;
    pulse();
    wait_idle();

    // Random sparse ticks with changing inputs.
    repeat (3000) begin
      drive($urandom_range(0, 79) == 0);
      red_seq = SLOTS'($urandom); yellow_seq = SLOTS'($urandom);
    end
    // Dense ticks: back-to-back restarts and ticks on the DONE edge.
    repeat (1500) begin
      drive($urandom_range(0, 3) == 0);
      red_seq = SLOTS'($urandom); yellow_seq = SLOTS'($urandom);
    end
    wait_idle();
    idle_n(2);

    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
